// File: rtl/flatten_packer.sv
// Collects one frame of pooled activations, saturates each to a packed pixel,
// then holds the frame and requests the dense layer until it reports done.
module flatten_packer #(
    parameter int N_PIX = 1600,
    parameter int IN_W  = 16,
    parameter int PIX_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [N_PIX*PIX_W-1:0]  img,
    output logic                    start,
    input  logic                    done,
    output logic                    err,
    output logic [15:0]             frame_cnt
);
    localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
    localparam logic [PIX_W-1:0] SAT_HI = {1'b0, {(PIX_W-1){1'b1}}};
    localparam logic [PIX_W-1:0] SAT_LO = {1'b1, {(PIX_W-1){1'b0}}};

    typedef enum logic [1:0] {FILL, ISSUE, WAIT_DONE} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx;
    logic                 accept, at_last;
    logic [IN_W-PIX_W:0]  hi;
    logic [PIX_W-1:0]     pix;

    assign in_ready = (state == FILL) && !rst;
    assign start    = (state != FILL);
    assign accept   = in_valid && in_ready;
    assign at_last  = (idx == LAST_IDX);

    // The value fits when every bit above the pixel sign bit matches it.
    assign hi = in_data[IN_W-1:PIX_W-1];
    always_comb begin
        pix = in_data[PIX_W-1:0];
        if (!((&hi) || !(|hi)))
            pix = in_data[IN_W-1] ? SAT_LO : SAT_HI;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:      if (accept && at_last) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (done) state_nxt = FILL;
            default:   state_nxt = FILL;
        endcase
    end

    // An early in_last or a missing in_last on the final beat is a length mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err <= accept && (in_last != at_last);
            if (accept)
                idx <= (at_last || in_last) ? '0 : idx + 1'b1;
            if (state == WAIT_DONE && done)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    for (genvar k = 0; k < N_PIX; k++) begin : g_pix
        always_ff @(posedge clk) begin
            if (rst)
                img[k*PIX_W +: PIX_W] <= '0;
            else if (accept && idx == IDX_W'(k))
                img[k*PIX_W +: PIX_W] <= pix;
        end
    end
endmodule

// File: tb/tb_flatten_packer.sv
// Scoreboard bench: stimulus queues expected frames/err events, a monitor
// compares them when start rises or err pulses.
module tb_flatten_packer;
    localparam int N_PIX = 1600;
    localparam int IN_W  = 16;
    localparam int PIX_W = 12;
    localparam int IMG_W = N_PIX * PIX_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic signed [IN_W-1:0] in_data;
    logic                   in_valid, in_last, in_ready;
    logic [IMG_W-1:0]       img;
    logic                   start, done, err;
    logic [15:0]            frame_cnt;

    int total = 0;
    int bad   = 0;

    logic [IMG_W-1:0] img_q[$];
    logic             err_q[$];   // expected value of start when err pulses

    flatten_packer #(.N_PIX(N_PIX), .IN_W(IN_W), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .img(img), .start(start),
        .done(done), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int beat_val(input int kind, input int k);
        case (kind)
            1:       return (k == 0) ? 5000 : (k == 1) ? -3000 : (k == 2) ? 100 : k % 2048;
            2:       return -k - 1;
            3:       return k * 3 - 2400;
            default: return k % 2048;
        endcase
    endfunction

    function automatic logic [PIX_W-1:0] sat12(input int v);
        int c;
        c = (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
        return c[PIX_W-1:0];
    endfunction

    task automatic push_img(input int kind);
        logic [IMG_W-1:0] e;
        e = '0;
        for (int k = 0; k < N_PIX; k++) e[k*PIX_W +: PIX_W] = sat12(beat_val(kind, k));
        img_q.push_back(e);
    endtask

    task automatic send(input logic signed [IN_W-1:0] d, input logic l, input bit bp);
        int n;
        if (bp) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0; in_data = IN_W'($urandom); in_last = 1'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) chk("send_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic fill(input int kind, input int n, input bit lastf, input bit bp);
        for (int k = 0; k < n; k++)
            send(IN_W'(beat_val(kind, k)), (k == n - 1) ? lastf : 1'b0, bp);
    endtask

    // Holds done low with junk beats offered, then completes the handshake.
    task automatic do_done(input int exp_cnt);
        logic [IMG_W-1:0] snap;
        snap = img;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'sh0123; in_last = 1'b1;
            chk("hold_start", 64'(start), 64'(1));
            chk("hold_img", 64'(img == snap), 64'(1));
            chk("hold_ready", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("done_start", 64'(start), 64'(0));
        chk("done_cnt", 64'(frame_cnt), 64'(exp_cnt));
        chk("done_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_cnt", 64'(frame_cnt), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_img", 64'(img == '0), 64'(1));
        chk("rst_ready_after", 64'(in_ready), 64'(1));
    endtask

    initial begin : monitor
        logic ps, pe;
        logic [IMG_W-1:0] e;
        int first;
        ps = 1'b0; pe = 1'b0;
        forever begin
            @(negedge clk);
            if (start && !ps) begin
                total++;
                if (img_q.size() == 0) begin
                    bad++;
                    $display("FAIL start_unexpected: got start=1 want no frame pending");
                end else begin
                    e = img_q.pop_front();
                    if (img !== e) begin
                        bad++;
                        first = 0;
                        while (first < N_PIX - 1 && img[first*PIX_W +: PIX_W] === e[first*PIX_W +: PIX_W])
                            first++;
                        $display("FAIL frame_img: pixel %0d got %0h want %0h", first,
                                 img[first*PIX_W +: PIX_W], e[first*PIX_W +: PIX_W]);
                    end
                end
            end
            if (err) begin
                if (err_q.size() == 0) chk("err_unexpected", 64'(err), 64'(0));
                else                   chk("err_start", 64'(start), 64'(err_q.pop_front()));
                if (pe) chk("err_width", 64'(pe), 64'(0));
            end
            ps = start;
            pe = err;
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("init_start", 64'(start), 64'(0));
        chk("init_err", 64'(err), 64'(0));
        chk("init_cnt", 64'(frame_cnt), 64'(0));
        chk("init_img", 64'(img == '0), 64'(1));
        chk("init_ready", 64'(in_ready), 64'(1));

        // Full frame, k mod 2048; done offered during ISSUE must be ignored.
        push_img(0);
        fill(0, N_PIX, 1'b1, 1'b0);
        @(negedge clk);
        chk("a_start", 64'(start), 64'(1));
        chk("a_ready", 64'(in_ready), 64'(0));
        chk("a_err", 64'(err), 64'(0));
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        @(negedge clk);
        chk("a_issue_done_ignored", 64'(start), 64'(1));
        chk("a_cnt_hold", 64'(frame_cnt), 64'(0));
        do_done(1);

        // Saturation with random backpressure.
        push_img(1);
        fill(1, N_PIX, 1'b1, 1'b1);
        @(negedge clk);
        chk("b_start", 64'(start), 64'(1));
        chk("b_pix0", 64'(img[11:0]), 64'(12'h7FF));
        chk("b_pix1", 64'(img[23:12]), 64'(12'h800));
        chk("b_pix2", 64'(img[35:24]), 64'(12'h064));
        do_done(2);

        // Early in_last at index 9, then a full frame that restarts at pixel 0.
        err_q.push_back(1'b0);
        fill(2, 10, 1'b1, 1'b0);
        @(negedge clk);
        chk("c_start", 64'(start), 64'(0));
        chk("c_ready", 64'(in_ready), 64'(1));
        push_img(2);
        fill(2, N_PIX, 1'b1, 1'b1);
        @(negedge clk);
        chk("c2_start", 64'(start), 64'(1));
        chk("c2_pix0", 64'(img[11:0]), 64'(12'hFFF));
        do_done(3);

        // Final beat without in_last: err pulse and frame still issued.
        err_q.push_back(1'b1);
        push_img(3);
        fill(3, N_PIX, 1'b0, 1'b0);
        @(negedge clk);
        chk("d_start", 64'(start), 64'(1));
        do_done(4);

        // Reset mid-fill at beat 800, then a normal frame.
        fill(0, 800, 1'b0, 1'b1);
        reset_pulse();
        push_img(0);
        fill(0, N_PIX, 1'b1, 1'b0);
        @(negedge clk);
        chk("e_start", 64'(start), 64'(1));
        do_done(1);

        // Reset while waiting for done drops the pending frame.
        push_img(2);
        fill(2, N_PIX, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("g_start_wait", 64'(start), 64'(1));
        reset_pulse();

        repeat (3) @(negedge clk);
        chk("img_q_empty", 64'(img_q.size()), 64'(0));
        chk("err_q_empty", 64'(err_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flatten_packer.md
FLATTEN_PACKER -- requirements
Module: flatten_packer

Interface
REQ-001 SHALL have parameter N_PIX, default 1600, number of activations per frame.
REQ-002 SHALL have parameter IN_W, default 16, width of the incoming signed activation.
REQ-003 SHALL have parameter PIX_W, default 12, width of each packed signed pixel.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_data, input, IN_W, signed activation from the pooling stage.
REQ-007 SHALL have port in_valid, input, 1, in_data/in_last valid.
REQ-008 SHALL have port in_last, input, 1, marks the final activation of a frame.
REQ-009 SHALL have port in_ready, output, 1, packer can accept a beat.
REQ-010 SHALL have port img, output, N_PIX*PIX_W (19200), packed frame for the dense layer.
REQ-011 SHALL have port start, output, 1, request to the dense layer.
REQ-012 SHALL have port done, input, 1, dense layer completion.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on frame-length mismatch.
REQ-014 SHALL have port frame_cnt, output, 16, number of frames completed by the dense layer.

Function
REQ-015 SHALL implement FSM states FILL, ISSUE, WAIT_DONE.
REQ-016 SHALL accept a beat on a rising edge only when in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready=1 in FILL and 0 in ISSUE and WAIT_DONE.
REQ-018 SHALL keep an index counter 0..N_PIX-1 that increments per accepted beat.
REQ-019 SHALL saturate each beat to PIX_W signed: values above 2047 become 2047, values below -2048 become -2048, other values are truncated losslessly.
REQ-020 SHALL write the beat with index k to img[12k+11:12k], so pixel 0 is in the LSBs.
REQ-021 SHALL, on accepting index N_PIX-1, reset the counter to 0 and enter ISSUE on the next cycle.
REQ-022 SHALL, on accepting a beat with in_last=1 at index < N_PIX-1, pulse err for 1 cycle, reset the counter to 0, stay in FILL and discard the partial frame; img contents are don't-care until refilled.
REQ-023 SHALL, on accepting index N_PIX-1 with in_last=0, pulse err for 1 cycle and still issue the frame.
REQ-024 SHALL assert start=1 in ISSUE and WAIT_DONE, and 0 in FILL.
REQ-025 SHALL move ISSUE->WAIT_DONE unconditionally after 1 cycle.
REQ-026 SHALL hold img constant throughout ISSUE and WAIT_DONE.
REQ-027 SHALL, when done=1 is sampled in WAIT_DONE, move to FILL with start=0 and increment frame_cnt, wrapping 0xFFFF->0.
REQ-028 SHALL ignore done in FILL and ISSUE.
REQ-029 SHALL give start-to-first-beat latency: the first beat of the next frame is acceptable 1 cycle after done is sampled.
REQ-030 SHALL make err registered, never high for more than one consecutive cycle per event.

Reset
REQ-031 SHALL, when rst=1 at a rising edge, force state=FILL, counter=0, start=0, err=0, frame_cnt=0 and img=0.
REQ-032 SHALL drive in_ready=0 during the rst cycle and 1 from the first cycle after rst deasserts.
REQ-033 SHALL let rst abort any frame mid-fill or mid-WAIT_DONE; the partial or pending frame is lost and start drops at that edge.
REQ-034 SHALL give rst priority over in_valid and done in the same cycle.

Verification
REQ-035 SHALL test a full frame: 1600 beats of value k mod 2048, last beat with in_last=1 -> img[12k+11:12k]=k mod 2048, start=1 the cycle after beat 1599, in_ready=0, err=0.
REQ-036 SHALL test saturation: in_data=16'sd5000 at beat 0, -16'sd3000 at beat 1, 16'sd100 at beat 2 -> pixels 2047, -2048 (0x800) and 100.
REQ-037 SHALL test an early in_last at index 9 -> err pulses 1 cycle, next beat is written to pixel 0, start stays 0.
REQ-038 SHALL test the done handshake: done held 0 for 50 cycles -> start=1 and img stable; done=1 -> start=0 next cycle, frame_cnt 0->1, in_ready=1.
REQ-039 SHALL test reset mid-fill at beat 800 -> start=0, frame_cnt=0, and a following 1600-beat frame issues normally.
REQ-040 SHALL test backpressure: in_valid toggled randomly -> only beats with in_valid=1 and in_ready=1 are counted, and none are accepted during WAIT_DONE.
